// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// =============================================================================
// Module   : riscv_mem_pkg
// Brief    : Access-size encodings, LOAD opcode and MMIO offsets for data_mem_ctrl.
// Revision : 1.0
// =============================================================================
package riscv_mem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [3:0] MMIO_CYC = 4'h0;
  localparam logic [3:0] MMIO_STC = 4'h4;
  localparam logic [3:0] MMIO_IO  = 4'h8;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (f3)
      SZ_H, SZ_HU: mis = lane[0];
      SZ_W:        mis = |lane;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : data_mem_if
// Brief    : MW-stage data port between the core (master) and data_mem_ctrl (slave).
// Revision : 1.0
// =============================================================================
interface data_mem_if;
  logic        MemWriteMW;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] InstrMW;
  logic [31:0] ReadData;
  logic [31:0] io_out;
  logic        misalign_err;

  modport master (
    output MemWriteMW, Mem_WrAddr, Mem_WrData, InstrMW,
    input  ReadData, io_out, misalign_err
  );

  modport slave (
    input  MemWriteMW, Mem_WrAddr, Mem_WrData, InstrMW,
    output ReadData, io_out, misalign_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl_load_extend.sv
`default_nettype none
// =============================================================================
// Module   : load_extend
// Brief    : Selects byte/half/word from a 32-bit word by lane and extends it.
// Revision : 1.0
// =============================================================================
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  // Half selection ignores lane[0], so unaligned halves fold onto the aligned one.
  assign byte_w = 8'(word_i >> {lane_i, 3'b000});
  assign half_w = lane_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = '0;
    case (funct3_i)
      SZ_B:    data_o = {{24{byte_w[7]}}, byte_w};
      SZ_BU:   data_o = {24'h0, byte_w};
      SZ_H:    data_o = {{16{half_w[15]}}, half_w};
      SZ_HU:   data_o = {16'h0, half_w};
      SZ_W:    data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : data_mem_ctrl
// Brief    : RV32I data-memory responder: lane-masked stores, extended loads,
//            cycle/store counters and an output register in an MMIO window.
//            Define MISALIGN_CHECK_EN to suppress misaligned accesses.
// Revision : 1.0
// =============================================================================
module data_mem_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int IDXW = $clog2(DEPTH);

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     cyc_q, cyc_d;
  logic [31:0]     stc_q, stc_d;
  logic [31:0]     io_q, io_d;

  logic [2:0]      f3_w;
  logic [1:0]      lane_w;
  logic [IDXW-1:0] idx_w;
  logic            is_load_w, is_store_w, block_w, st_ok_w;
  logic            in_ram_w, in_mmio_w;
  logic [3:0]      be_w;
  logic [31:0]     wdata_w, rword_w, ext_w;
  logic            unused_w;

  assign f3_w       = bus.InstrMW[14:12];
  assign lane_w     = bus.Mem_WrAddr[1:0];
  assign idx_w      = bus.Mem_WrAddr[IDXW+1:2];
  assign is_load_w  = (bus.InstrMW[6:0] == OPC_LOAD);
  assign is_store_w = bus.MemWriteMW && (f3_w == SZ_B || f3_w == SZ_H || f3_w == SZ_W);
  assign in_ram_w   = (bus.Mem_WrAddr[31:IDXW+2] == '0);
  assign in_mmio_w  = (bus.Mem_WrAddr[31:4] == MMIO_BASE[31:4]);
  assign unused_w   = ^{bus.InstrMW[31:15], bus.InstrMW[11:7]};

`ifdef MISALIGN_CHECK_EN
  logic err_q;
  assign block_w          = is_misaligned(f3_w, lane_w);
  assign bus.misalign_err = err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((is_load_w || is_store_w) && block_w) begin
      err_q <= 1'b1;
    end
  end
`else
  assign block_w          = 1'b0;
  assign bus.misalign_err = 1'b0;
`endif

  assign st_ok_w = is_store_w && !block_w;

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be_w    = 4'b0000;
    wdata_w = bus.Mem_WrData;
    case (f3_w)
      SZ_B: begin
        be_w    = 4'b0001 << lane_w;
        wdata_w = {4{bus.Mem_WrData[7:0]}};
      end
      SZ_H: begin
        be_w    = lane_w[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{bus.Mem_WrData[15:0]}};
      end
      SZ_W:    be_w = 4'b1111;
      default: be_w = 4'b0000;
    endcase
  end

  always_comb begin
    rword_w = '0;
    if (in_ram_w) begin
      rword_w = mem_q[idx_w];
    end else if (in_mmio_w) begin
      case ({bus.Mem_WrAddr[3:2], 2'b00})
        MMIO_CYC: rword_w = cyc_q;
        MMIO_STC: rword_w = stc_q;
        MMIO_IO:  rword_w = io_q;
        default:  rword_w = '0;
      endcase
    end
  end

  load_extend u_load_extend (
    .word_i   (rword_w),
    .lane_i   (lane_w),
    .funct3_i (f3_w),
    .data_o   (ext_w)
  );

  assign bus.ReadData = (is_load_w && !block_w) ? ext_w : 32'h0;
  assign bus.io_out   = io_q;

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    stc_d = st_ok_w ? stc_q + 32'd1 : stc_q;
    io_d  = io_q;
    if (st_ok_w && in_mmio_w && ({bus.Mem_WrAddr[3:2], 2'b00} == MMIO_IO)) begin
      for (int l = 0; l < 4; l++) begin
        if (be_w[l]) io_d[l*8 +: 8] = wdata_w[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      stc_q <= '0;
      io_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      stc_q <= stc_d;
      io_q  <= io_d;
    end
  end

  // RAM contents survive reset; only the store itself is gated by it.
  always_ff @(posedge clk) begin
    if (!reset && st_ok_w && in_ram_w) begin
      for (int l = 0; l < 4; l++) begin
        if (be_w[l]) mem_q[idx_w][l*8 +: 8] <= wdata_w[l*8 +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Directed self-checking bench for data_mem_ctrl (honours MISALIGN_CHECK_EN).
// Revision : 1.0
// =============================================================================
module tb_data_mem_ctrl;

  localparam logic [31:0] MMIO = 32'hFFFF_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_stc;
  logic [31:0] rd;
  logic [31:0] c0;

  data_mem_if bus ();

  data_mem_ctrl #(.DEPTH(1024), .MMIO_BASE(MMIO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; occupies exactly one cycle.
  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    bus.MemWriteMW = 1'b1;
    bus.InstrMW    = {17'h0, f3, 5'h0, 7'b0100011};
    bus.Mem_WrAddr = addr;
    bus.Mem_WrData = data;
    @(negedge clk);
    bus.MemWriteMW = 1'b0;
    bus.InstrMW    = NOP;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, output logic [31:0] data);
    bus.InstrMW    = {17'h0, f3, 5'h0, 7'b0000011};
    bus.Mem_WrAddr = addr;
    #2;
    data = bus.ReadData;
    @(negedge clk);
    bus.InstrMW = NOP;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_stc = 0;
    reset   = 1'b1;
    bus.MemWriteMW = 1'b0;
    bus.InstrMW    = NOP;
    bus.Mem_WrAddr = 32'h0;
    bus.Mem_WrData = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_io_out", bus.io_out, 32'h0);
    chk("rst_err", {31'h0, bus.misalign_err}, 32'h0);
    @(negedge clk);
    do_load(3'b010, MMIO + 32'h4, rd); chk("rst_stc", rd, 32'h0);

    // Known RAM value, then a store during reset must be dropped.
    do_store(3'b010, 32'h40, 32'hCAFE_F00D);
    reset = 1'b1;
    do_store(3'b010, 32'h40, 32'h1111_1111);
    reset = 1'b0;
    do_load(3'b010, MMIO, rd); chk("cyc_after_rst", rd, 32'd0);
    repeat (9) @(negedge clk);
    do_load(3'b010, MMIO, rd); chk("cyc_10", rd, 32'd10);
    do_load(3'b010, MMIO + 32'h4, rd); chk("stc_after_rst", rd, 32'h0);
    do_load(3'b010, 32'h40, rd); chk("sw_in_reset", rd, 32'hCAFE_F00D);

    do_store(3'b010, 32'h10, 32'hDEAD_BEEF); exp_stc++;
    do_load(3'b000, 32'h11, rd); chk("lb", rd, 32'hFFFF_FFBE);
    do_load(3'b100, 32'h11, rd); chk("lbu", rd, 32'h0000_00BE);
    do_load(3'b001, 32'h12, rd); chk("lh", rd, 32'hFFFF_DEAD);
    do_load(3'b101, 32'h12, rd); chk("lhu", rd, 32'h0000_DEAD);
    do_load(3'b010, 32'h10, rd); chk("lw", rd, 32'hDEAD_BEEF);
    do_load(3'b000, 32'h13, rd); chk("lb_l3", rd, 32'hFFFF_FFDE);
    do_load(3'b100, 32'h10, rd); chk("lbu_l0", rd, 32'h0000_00EF);
    do_load(3'b101, 32'h10, rd); chk("lhu_l0", rd, 32'h0000_BEEF);

    do_store(3'b010, 32'h20, 32'h0);         exp_stc++;
    do_store(3'b000, 32'h23, 32'h0000_005A); exp_stc++;
    do_store(3'b001, 32'h20, 32'hFFFF_1234); exp_stc++;
    do_load(3'b010, 32'h20, rd); chk("merge", rd, 32'h5A00_1234);

    do_store(3'b001, MMIO + 32'h8, 32'h5555_ABCD); exp_stc++;
    #1 chk("io_sh", bus.io_out, 32'h0000_ABCD);
    do_store(3'b000, MMIO + 32'hB, 32'h0000_0077); exp_stc++;
    do_load(3'b010, MMIO + 32'h8, rd); chk("io_rd", rd, 32'h7700_ABCD);
    do_load(3'b100, MMIO + 32'hB, rd); chk("io_lbu", rd, 32'h0000_0077);

    do_load(3'b010, MMIO, c0);
    do_store(3'b010, MMIO, 32'h1234_5678); exp_stc++;
    do_load(3'b010, MMIO, rd); chk("cyc_ro", rd, c0 + 32'd2);
    do_load(3'b010, MMIO + 32'h4, rd); chk("stc", rd, 32'(exp_stc));
    do_load(3'b010, MMIO + 32'hC, rd); chk("mmio_c", rd, 32'h0);

    do_store(3'b010, 32'h1000, 32'hFFFF_FFFF); exp_stc++;
    do_load(3'b010, 32'h1000, rd); chk("oob_rd", rd, 32'h0);
    do_load(3'b010, 32'h8000_0000, rd); chk("hole_rd", rd, 32'h0);
    do_store(3'b011, 32'h20, 32'hFFFF_FFFF);
    do_load(3'b010, 32'h20, rd); chk("bad_f3_st", rd, 32'h5A00_1234);
    do_load(3'b011, 32'h10, rd); chk("bad_f3_ld", rd, 32'h0);
    bus.InstrMW = NOP; bus.Mem_WrAddr = 32'h10; #2;
    chk("no_load", bus.ReadData, 32'h0);
    @(negedge clk);
    do_load(3'b010, MMIO + 32'h4, rd); chk("stc_drops", rd, 32'(exp_stc));

`ifdef MISALIGN_CHECK_EN
    do_store(3'b010, 32'h42, 32'h89AB_CDEF);
    do_load(3'b010, 32'h40, rd); chk("mis_sw", rd, 32'hCAFE_F00D);
    do_load(3'b001, 32'h41, rd); chk("mis_lh", rd, 32'h0);
    chk("mis_err", {31'h0, bus.misalign_err}, 32'h1);
    repeat (3) @(negedge clk);
    chk("mis_err_hold", {31'h0, bus.misalign_err}, 32'h1);
`else
    do_store(3'b010, 32'h42, 32'h89AB_CDEF); exp_stc++;
    do_load(3'b010, 32'h40, rd); chk("mis_sw", rd, 32'h89AB_CDEF);
    do_load(3'b001, 32'h41, rd); chk("mis_lh", rd, 32'hFFFF_CDEF);
    chk("mis_err", {31'h0, bus.misalign_err}, 32'h0);
`endif
    do_load(3'b010, MMIO + 32'h4, rd); chk("stc_final", rd, 32'(exp_stc));

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_io", bus.io_out, 32'h0);
    chk("rst2_err", {31'h0, bus.misalign_err}, 32'h0);
    do_load(3'b010, 32'h10, rd); chk("ram_kept", rd, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
